bin2bcd_six: RTL

Sequential binary-to-BCD converter that produces the six packed BCD digits consumed by the six-digit seven-segment scanning display stage. It accepts a 20-bit unsigned binary value on a start strobe and runs a double-dabble (shift/add-3) conversion, one bit per clock. It presents the result as a 24-bit packed word, digit 0 in bits [3:0], with a one-cycle done pulse. Counters, timers and measurement blocks feed their binary values through it to the display.

---
 rtl/bin2bcd_six_pkg.sv | 23 ++
 rtl/bin2bcd_six_if.sv | 35 +++
 rtl/bin2bcd_six_bcd_digit_adj.sv | 15 +
 rtl/bin2bcd_six.sv | 115 +++++++++++
 4 files changed

// File: rtl/bin2bcd_six_pkg.sv
`default_nettype none
// ============================================================================
// bin2bcd_six_pkg : shared constants and FSM encoding for bin2bcd_six
// Revision: 1.0
// ============================================================================
package bin2bcd_six_pkg;

    localparam int BIN_W  = 20;
    localparam int DIGITS = 6;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] BIT_CNT_LAST = 5'd19;
    localparam logic [BIN_W-1:0] BCD_MAX_BIN  = 20'd999999;
    localparam logic [BCD_W-1:0] BCD_SAT_PAT  = 24'h999999;
    localparam logic [BCD_W-1:0] BCD_ERR_PAT  = 24'hEEEEEE;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage : bin2bcd_six_pkg
`default_nettype wire

// File: rtl/bin2bcd_six_if.sv
`default_nettype none
// ============================================================================
// bin2bcd_six_if : request/result bundle between a client and bin2bcd_six
// Revision: 1.0
// ============================================================================
interface bin2bcd_six_if;
    import bin2bcd_six_pkg::*;

    logic             Start;
    logic [BIN_W-1:0] Bin_In;
    logic             Busy;
    logic             Done;
    logic [BCD_W-1:0] Bcd_SixNum;
    logic             Overflow;

    modport master (
        output Start,
        output Bin_In,
        input  Busy,
        input  Done,
        input  Bcd_SixNum,
        input  Overflow
    );

    modport slave (
        input  Start,
        input  Bin_In,
        output Busy,
        output Done,
        output Bcd_SixNum,
        output Overflow
    );

endinterface : bin2bcd_six_if
`default_nettype wire

// File: rtl/bin2bcd_six_bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// bcd_digit_adj : double-dabble digit corrector, adds 3 when digit >= 5
// Revision: 1.0
// ============================================================================
module bcd_digit_adj (
    input  wire logic [3:0] digit_i,
    output logic      [3:0] digit_o
);

    // Wraps modulo 16; only reachable for out-of-range operands, whose result is replaced anyway.
    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin2bcd_six.sv
`default_nettype none
// ============================================================================
// bin2bcd_six : sequential 20-bit binary to 6-digit packed BCD (double dabble)
// Build option: OVERFLOW_SAT_EN selects 999999 saturation instead of EEEEEE.
// Revision: 1.0
// ============================================================================
module bin2bcd_six
    import bin2bcd_six_pkg::*;
(
    input  wire logic   CLK,
    input  wire logic   RSTn,
    bin2bcd_six_if.slave bus
);

`ifdef OVERFLOW_SAT_EN
    localparam logic [BCD_W-1:0] OVF_PAT = BCD_SAT_PAT;
`else
    localparam logic [BCD_W-1:0] OVF_PAT = BCD_ERR_PAT;
`endif

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_lat_q, ovf_lat_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;
    logic             ovf_q,   ovf_d;

    logic [BCD_W-1:0] acc_adj;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*gi +: 4]),
            .digit_o (acc_adj[4*gi +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_lat_d = ovf_lat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    shreg_d   = bus.Bin_In;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_lat_d = (bus.Bin_In > BCD_MAX_BIN);
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Digit-5 MSB falls off the top; only matters for overflow operands.
                acc_d   = {acc_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
                shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == BIT_CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = ovf_lat_q ? OVF_PAT : acc_q;
                ovf_d   = ovf_lat_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_lat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_lat_q <= ovf_lat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Bcd_SixNum = bcd_q;
    assign bus.Overflow   = ovf_q;

endmodule : bin2bcd_six
`default_nettype wire
